// File: rtl/ca3_phase_memory_n.sv
// ca3_phase_memory_n: theta-gated associative memory with a symmetric saturating Hebbian
// weight matrix. It learns at theta peaks, recalls with iterative completion at troughs, and decays weights.

module ca3_phase_memory_n #(
    parameter int WIDTH         = 18,
    parameter int FRAC          = 14,
    parameter int N_UNITS       = 6,
    parameter int WEIGHT_W      = 4,
    parameter int THETA_HI      = 12288,
    parameter int THETA_LO      = -12288,
    parameter int RECALL_ITERS  = 4,
    parameter int RECALL_THRESH = 2,
    parameter int DECAY_PERIOD  = 4000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic signed [WIDTH-1:0]    theta_x,
    input  logic [N_UNITS-1:0]         pattern_in,
    input  logic                       learn_en,
    input  logic [$clog2(N_UNITS)-1:0] rd_row,
    input  logic [$clog2(N_UNITS)-1:0] rd_col,
    output logic [WEIGHT_W-1:0]        rd_weight,
    output logic [N_UNITS-1:0]         phase_pattern,
    output logic                       learning,
    output logic                       recalling,
    output logic                       recall_done,
    output logic [3:0]                 debug_state
);

    localparam int IDX_W    = $clog2(N_UNITS);
    localparam int ACT_W    = WEIGHT_W + IDX_W;
    localparam int NPAIR    = N_UNITS * (N_UNITS - 1) / 2;
    localparam int ITER_W   = (RECALL_ITERS > 1) ? $clog2(RECALL_ITERS) : 1;
    localparam int CNT_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam bit DECAY_EN = (DECAY_PERIOD > 0);
    // The sign bit sits at the top of the integer field above the FRAC fractional bits.
    localparam int SIGN_BIT = FRAC + (WIDTH - FRAC) - 1;
    localparam logic signed [WIDTH-1:0] HI_V = WIDTH'(THETA_HI);
    localparam logic signed [WIDTH-1:0] LO_V = WIDTH'(THETA_LO);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LEARN      = 2'd1,
        WAIT_RESET = 2'd2,
        RECALL     = 2'd3
    } state_t;

    // Row-major index of the upper-triangle pair (i, j), i < j.
    function automatic int pair_idx(input int i, input int j);
        return i * N_UNITS - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    state_t               state_q, state_d;
    logic [WEIGHT_W-1:0]  w_q [NPAIR];
    logic [WEIGHT_W-1:0]  w_d [NPAIR];
    logic [WEIGHT_W-1:0]  w_full [N_UNITS][N_UNITS];
    logic [ACT_W-1:0]     act [N_UNITS];
    logic [N_UNITS-1:0]   s_q, s_d, cue_q, cue_d, phase_q, phase_d, recall_s;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 learn_armed_q, learn_armed_d, recall_armed_q, recall_armed_d;
    logic                 sign_q, sign_d;
    logic                 learning_q, learning_d, recalling_q, recalling_d, done_q, done_d;
    logic                 theta_sign, ge_hi, le_lo, learn_go, recall_go;

    assign theta_sign = theta_x[SIGN_BIT];
    assign ge_hi      = theta_x >= HI_V;
    assign le_lo      = theta_x <= LO_V;
    assign learn_go   = ge_hi && learn_armed_q && (|pattern_in) && learn_en;
    assign recall_go  = le_lo && recall_armed_q && (|pattern_in);

    always_comb begin
        for (int i = 0; i < N_UNITS; i++) begin
            for (int j = 0; j < N_UNITS; j++) begin
                w_full[i][j] = '0;
                if (i < j)
                    w_full[i][j] = w_q[pair_idx(i, j)];
                else if (i > j)
                    w_full[i][j] = w_q[pair_idx(j, i)];
            end
        end
    end

    always_comb begin
        rd_weight = '0;
        if (int'(rd_row) < N_UNITS && int'(rd_col) < N_UNITS)
            rd_weight = w_full[rd_row][rd_col];
    end

    // Unit activations from the current recall state; the cue bits are always kept on.
    always_comb begin
        for (int i = 0; i < N_UNITS; i++) begin
            act[i] = '0;
            for (int j = 0; j < N_UNITS; j++) begin
                if (s_q[j])
                    act[i] = act[i] + ACT_W'(w_full[i][j]);
            end
            recall_s[i] = cue_q[i] | (act[i] >= ACT_W'(RECALL_THRESH));
        end
    end

    always_comb begin
        state_d        = state_q;
        w_d            = w_q;
        s_d            = s_q;
        cue_d          = cue_q;
        phase_d        = phase_q;
        iter_d         = iter_q;
        cnt_d          = cnt_q;
        learn_armed_d  = learn_armed_q;
        recall_armed_d = recall_armed_q;
        sign_d         = sign_q;
        done_d         = 1'b0;

        if (clk_en) begin
            sign_d = theta_sign;
            if (theta_sign != sign_q) begin
                learn_armed_d  = 1'b1;
                recall_armed_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (learn_go) begin
                        state_d       = LEARN;
                        learn_armed_d = 1'b0;
                        cue_d         = pattern_in;
                    end else if (recall_go) begin
                        state_d        = RECALL;
                        recall_armed_d = 1'b0;
                        s_d            = pattern_in;
                        cue_d          = pattern_in;
                        iter_d         = '0;
                    end
                    // A due decay stays pending across a learn entry and fires on the next idle update.
                    if (DECAY_EN) begin
                        if (cnt_q == CNT_W'(DECAY_PERIOD - 1)) begin
                            if (!learn_go) begin
                                cnt_d = '0;
                                for (int k = 0; k < NPAIR; k++) begin
                                    if (w_q[k] != '0)
                                        w_d[k] = w_q[k] - WEIGHT_W'(1);
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                LEARN: begin
                    for (int i = 0; i < N_UNITS; i++) begin
                        for (int j = 0; j < N_UNITS; j++) begin
                            if (i < j) begin
                                if (cue_q[i] & cue_q[j]) begin
                                    if (w_q[pair_idx(i, j)] != '1)
                                        w_d[pair_idx(i, j)] = w_q[pair_idx(i, j)] + WEIGHT_W'(1);
                                end else if (cue_q[i] ^ cue_q[j]) begin
                                    if (w_q[pair_idx(i, j)] != '0)
                                        w_d[pair_idx(i, j)] = w_q[pair_idx(i, j)] - WEIGHT_W'(1);
                                end
                            end
                        end
                    end
                    state_d = WAIT_RESET;
                end
                WAIT_RESET: begin
                    if (!ge_hi)
                        state_d = IDLE;
                end
                RECALL: begin
                    s_d = recall_s;
                    if (iter_q == ITER_W'(RECALL_ITERS - 1)) begin
                        phase_d = recall_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        iter_d = iter_q + ITER_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        learning_d  = (state_d == LEARN);
        recalling_d = (state_d == RECALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int k = 0; k < NPAIR; k++)
                w_q[k] <= '0;
            s_q            <= '0;
            cue_q          <= '0;
            phase_q        <= '0;
            iter_q         <= '0;
            cnt_q          <= '0;
            learn_armed_q  <= 1'b1;
            recall_armed_q <= 1'b1;
            sign_q         <= 1'b0;
            learning_q     <= 1'b0;
            recalling_q    <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            w_q            <= w_d;
            s_q            <= s_d;
            cue_q          <= cue_d;
            phase_q        <= phase_d;
            iter_q         <= iter_d;
            cnt_q          <= cnt_d;
            learn_armed_q  <= learn_armed_d;
            recall_armed_q <= recall_armed_d;
            sign_q         <= sign_d;
            learning_q     <= learning_d;
            recalling_q    <= recalling_d;
            done_q         <= done_d;
        end
    end

    assign phase_pattern = phase_q;
    assign learning      = learning_q;
    assign recalling     = recalling_q;
    assign recall_done   = done_q;
    assign debug_state   = {2'b00, state_q};

endmodule

// File: doc/ca3_phase_memory_n.md
# ca3_phase_memory_n

Parametrised N-unit theta-gated associative memory, the successor to the fixed 6-unit CA3 phase memory. It stores binary patterns in a symmetric saturating Hebbian weight matrix. Learning is gated to the theta peak and recall to the theta trough, with iterative pattern completion and periodic weight decay. It sits between the thalamic theta Hopf oscillator (`theta_x`) and the cortical column pattern inputs. All state advances only on `clk_en` strobes (4 kHz update rate).

## Interface
- WIDTH, 18: signed theta sample width.
- FRAC, 14: fractional bits of `theta_x`.
- N_UNITS, 6: pattern width (2..16).
- WEIGHT_W, 4: unsigned weight width; saturates at 2^WEIGHT_W-1.
- THETA_HI, 12288: learn threshold (theta_x >= THETA_HI).
- THETA_LO, -12288: recall threshold (theta_x <= THETA_LO).
- RECALL_ITERS, 4: completion iterations per recall (>=1).
- RECALL_THRESH, 2: activation threshold for unit turn-on.
- DECAY_PERIOD, 4000: clk_en updates between decay steps; 0 disables decay.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  update strobe.
- theta_x  in  WIDTH  signed theta phase signal.
- pattern_in  in  N_UNITS  training pattern (at peak) or recall cue (at trough).
- learn_en  in  1  0 blocks all weight increments (recall and decay unaffected).
- rd_row, rd_col  in  clog2(N_UNITS) each  weight readback address.
- rd_weight  out  WEIGHT_W  combinational w[rd_row][rd_col].
- phase_pattern  out  N_UNITS  last completed recall result.
- learning  out  1  high for exactly one clk_en period per learn event.
- recalling  out  1  high while recall iterations run.
- recall_done  out  1  one-clk pulse when phase_pattern updates.
- debug_state  out  4  FSM state encoding.

## Operation
- Weights: w[i][j] for i≠j, symmetric, diagonal fixed at 0. The implementation stores the upper triangle only.
- FSM states and debug_state values: IDLE=0, LEARN=1, WAIT_RESET=2, RECALL=3.
- Arm flags: `learn_armed` and `recall_armed` are set on the clk_en where theta_x crosses zero (sign change). Each is cleared when its event fires. This gives at most one learn per peak and one recall per trough.
- IDLE → LEARN: requires theta_x >= THETA_HI, learn_armed, pattern_in != 0, and learn_en.
- In LEARN (one clk_en), for each pair with i<j:
  - p_i&p_j: w += 1, saturating.
  - p_i^p_j: w -= 1, floored at 0.
  - neither active: unchanged.
  - Then go to WAIT_RESET.
- WAIT_RESET → IDLE occurs when theta_x < THETA_HI.
- IDLE → RECALL: requires theta_x <= THETA_LO, recall_armed, and pattern_in != 0. On entry, state vector s = pattern_in (cue latched) and the iteration counter = 0.
- In RECALL, each clk_en computes for each i: a_i = Σ_j w[i][j]·s_j, with an unsigned width of WEIGHT_W+clog2(N_UNITS).
  - Next s_i = cue_i | (a_i >= RECALL_THRESH).
  - After RECALL_ITERS updates: phase_pattern ← s, pulse recall_done, go to IDLE.
- Decay: a counter advances on each clk_en while in IDLE. When it reaches DECAY_PERIOD, every nonzero weight is decremented by 1 and the counter clears.
  - If decay and a LEARN entry coincide, learn takes priority and the decay is deferred to the next IDLE clk_en.
  - Decay never runs in LEARN or RECALL.
- Peak and trough conditions are mutually exclusive by thresholds, so no arbitration between learn and recall is needed.

## Timing
- Reset values: all weights 0, phase_pattern 0, learning 0, recalling 0, recall_done 0, debug_state 0, both arm flags 1, decay counter 0.
- Reset is asynchronous. Asserting rst_n mid-LEARN or mid-RECALL aborts the operation immediately, with no partial phase_pattern update.
- learning/recalling are registered and rise on the clk edge where clk_en samples the entry condition. learning falls on the next clk_en.
- Recall latency: RECALL_ITERS clk_en strobes from entry to recall_done. recall_done lasts one clk (not one clk_en) period.
- Without clk_en, all registers hold. pattern_in is sampled only on clk_en.

## Test plan
- Reset: hold rst_n low mid-stream → all outputs 0 and rd_weight 0 for every address.
- Learn gating: pattern_in=101010, drive theta through a peak (>=12288) → learning high for one clk_en. Then w[5][3]=w[5][1]=w[3][1]=1 and w[5][4]=0. Holding the peak for 50 more updates produces no second increment.
- Saturation: train 101010 over 20 peaks (WEIGHT_W=4) → w[5][3]=15, no wrap to 0. learn_en=0 peak → weights unchanged.
- Completion: train 101010 ×5, then 010101 ×5. Cue 100000 at trough → recalling for 4 updates, recall_done, phase_pattern=101010. Cue 000100 → 010101.
- Decay: DECAY_PERIOD=8, w[5][3]=3, idle 24 updates → w=0 and floored (stays 0 after 8 more updates).
- Abort: assert rst_n low during the second RECALL iteration → phase_pattern=0, recalling=0, no recall_done. After release, the next trough recall works normally.
